innerproduct_stream: RTL and testbench
======================================

Name: innerproduct_stream

Overview:
- Parametrised, sequential successor to the fixed 41-term combinational inner product of the logistic-regression datapath.
- Computes h = THETA[0] + sum over i=1..N_FEAT-1 of x[i]*THETA[i]. Feature x[0] is ignored; THETA[0] acts as the bias.
- Features arrive as a valid/ready stream, LANES per beat. THETA is held in an internal register file written at run time.
- Sits between the line buffer (feature source) and the sigmoid/decision stage (consumer of h).

Parameters:
- N_FEAT, 41, features per vector including x[0]; must be >= 2.
- DW, 32, width of one feature and one THETA word.
- LANES, 1, features per input beat; must be >= 1.
- ACC_W, 32, accumulator and result width; must be >= DW.
- AW, $clog2(N_FEAT), THETA address width.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- theta_we  in  1  THETA write strobe.
- theta_addr  in  AW  THETA index.
- theta_wdata  in  DW  THETA value.
- x_valid  in  1  input beat valid.
- x_ready  out  1  input beat accepted when x_valid && x_ready.
- x_data  in  LANES*DW  lane k in bits [k*DW +: DW]; holds feature beat*LANES+k.
- x_last  in  1  sender's end-of-vector marker; checked only, never trusted.
- h_valid  out  1  result valid.
- h_ready  in  1  result consumed when h_valid && h_ready.
- h_data  out  ACC_W  inner-product result.
- err  out  2  sticky error flags: [0] x_last mismatch, [1] THETA write dropped.
- err_clr  in  1  synchronous clear of err.

Behaviour:
- Reset (async assert, sync deassert handled upstream) sets:
  - state=IDLE, beat counter=0, accumulator=0;
  - h_valid=0, h_data=0, err=0, all THETA=0.
  - x_ready is 0 while rst_n is low and 1 in IDLE after release.
- NBEATS = ceil(N_FEAT/LANES). Feature index for lane k of beat b is b*LANES+k.
- Lanes with index 0 or index >= N_FEAT contribute 0 (index 0 contributes nothing, ignored completely; padding lanes in the final beat are ignored).
- Arithmetic:
  - Each product is DW x DW, truncated to its low ACC_W bits.
  - Sum is modulo 2^ACC_W.
  - Operands are two's-complement compatible; only the low ACC_W bits are specified.
  - THETA[0] is zero-extended to ACC_W.
- FSM states IDLE, ACCUM, OUTPUT. x_ready = (state != OUTPUT).
  - IDLE + accepted beat: acc <= THETA[0] + beat sum; counter <= 1. Go to ACCUM, or to OUTPUT if NBEATS==1.
  - ACCUM + accepted beat: acc <= acc + beat sum; counter++. On counter==NBEATS-1, go to OUTPUT.
  - Entering OUTPUT: h_data <= final sum, h_valid <= 1. Latency is 1 cycle from acceptance of the last beat.
  - OUTPUT: h_data is held stable while h_valid && !h_ready. On handshake: h_valid <= 0, counter <= 0, state <= IDLE.
  - One-cycle bubble: no input is accepted in the handshake cycle.
- x_last check:
  - x_last=1 on a non-final beat, or x_last=0 on the final beat, sets err[0].
  - The counter alone delimits vectors.
- THETA writes:
  - Accepted only in IDLE, and only when no input beat is accepted that same cycle.
  - Otherwise the write is dropped and err[1] is set.
  - The written value is visible to the next vector.
- err_clr clears both bits. A same-cycle new error wins over err_clr.
- Reset mid-vector discards the partial accumulation and any pending result; THETA returns to 0.

Decomposition:
- Shared package innerproduct_pkg holds:
  - state enum {IDLE, ACCUM, OUTPUT};
  - ERR_LAST=0 and ERR_THETA=1 bit indices;
  - function nbeats(N_FEAT, LANES).
- One sub-module, innerproduct_lane_sum: combinational LANES-wide multiply, mask and add tree producing the ACC_W beat sum.
  - Inputs: x_data, the beat's THETA slice, beat index.
  - Pipelining is not permitted; the latency stays at 1.

Test Plan:
- Basic (N_FEAT=5, LANES=2): THETA={10,2,3,4,5}, x={7,1,1,1,1} in 3 beats with x_last on beat 3 -> h_data=24, h_valid one cycle after beat 3, err=0.
- Wrap: THETA={10,0xFFFFFFFF,0,0,0}, x1=2, others 0 -> h_data=8.
- Backpressure: hold h_ready=0 for 5 cycles after the result -> h_data stable, x_ready=0 throughout. With h_ready=1, the next vector's first beat is accepted one cycle later and its result is correct.
- Dropped write: theta_we addr=1 data=9 during beat 2 -> THETA[1] unchanged (result still 24), err=2'b10. err_clr -> err=0.
- x_last on beat 1 of 3 -> err[0]=1, result still produced after beat 3 with value 24.
- Reset mid-vector: rst_n low after beat 2 -> h_valid=0, THETA=0. Reload THETA, send a full vector -> 24.

Source files
------------

// File: rtl/innerproduct_pkg.sv
// innerproduct_pkg
//   Shared declarations for the streaming inner-product block:
//   FSM state encoding, sticky error bit positions and the
//   beats-per-vector helper.
package innerproduct_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      OUTPUT
   } state_t;

   localparam int unsigned ERR_LAST  = 0;
   localparam int unsigned ERR_THETA = 1;

   // Number of input beats needed to carry n_feat features, lanes per beat.
   function automatic int unsigned nbeats(input int unsigned n_feat,
                                          input int unsigned lanes);
      return (n_feat + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/innerproduct_stream_if.sv
// innerproduct_stream_if
//   Bundles the THETA write port, the feature input stream, the result
//   output stream and the error flags of innerproduct_stream.
//   master: feature source / THETA loader / result consumer side.
//   slave : the inner-product block itself.
//   Signals:
//     theta_we/theta_addr/theta_wdata  THETA register-file write
//     x_valid/x_ready/x_data/x_last    feature beats, LANES per beat
//     h_valid/h_ready/h_data           inner-product result
//     err/err_clr                      sticky errors and their clear
interface innerproduct_stream_if #(
   parameter int unsigned N_FEAT = 41,
   parameter int unsigned DW     = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned AW     = $clog2(N_FEAT)
);
   logic                  theta_we;
   logic [AW-1:0]         theta_addr;
   logic [DW-1:0]         theta_wdata;
   logic                  x_valid;
   logic                  x_ready;
   logic [LANES*DW-1:0]   x_data;
   logic                  x_last;
   logic                  h_valid;
   logic                  h_ready;
   logic [ACC_W-1:0]      h_data;
   logic [1:0]            err;
   logic                  err_clr;

   modport master (
      output theta_we, theta_addr, theta_wdata,
      output x_valid, x_data, x_last,
      input  x_ready,
      input  h_valid, h_data,
      output h_ready,
      input  err,
      output err_clr
   );

   modport slave (
      input  theta_we, theta_addr, theta_wdata,
      input  x_valid, x_data, x_last,
      output x_ready,
      output h_valid, h_data,
      input  h_ready,
      output err,
      input  err_clr
   );
endinterface

// File: rtl/innerproduct_lane_sum.sv
// innerproduct_lane_sum
//   Combinational sum of x[k]*THETA[k] over the LANES lanes of one beat.
//   Lanes whose feature index is 0 (bias slot) or beyond N_FEAT-1
//   (padding in the final beat) contribute nothing.
//   Ports:
//     x_data      in  LANES*DW  feature beat, lane k at [k*DW +: DW]
//     theta_slice in  LANES*DW  THETA words aligned with the lanes
//     beat        in  CW        beat index within the vector
//     beat_sum    out ACC_W     sum of lane products, modulo 2^ACC_W
module innerproduct_lane_sum #(
   parameter int unsigned N_FEAT = 41,
   parameter int unsigned DW     = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned CW     = 6
) (
   input  logic [LANES*DW-1:0] x_data,
   input  logic [LANES*DW-1:0] theta_slice,
   input  logic [CW-1:0]       beat,
   output logic [ACC_W-1:0]    beat_sum
);

   always_comb begin
      beat_sum = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         int unsigned     idx;
         logic [2*DW-1:0] xe;
         logic [2*DW-1:0] te;
         logic [2*DW-1:0] prod;
         idx  = 32'(beat) * LANES + k;
         xe   = {{DW{1'b0}}, x_data[k*DW +: DW]};
         te   = {{DW{1'b0}}, theta_slice[k*DW +: DW]};
         prod = xe * te;
         if (idx != 0 && idx < N_FEAT) begin
            beat_sum = beat_sum + ACC_W'(prod);
         end
      end
   end

endmodule

// File: rtl/innerproduct_stream.sv
// innerproduct_stream
//   Sequential inner product h = THETA[0] + sum_{i=1..N_FEAT-1} x[i]*THETA[i]
//   over a valid/ready feature stream carrying LANES features per beat.
//   THETA lives in an internal register file written through theta_we.
//   Ports:
//     clk    in   rising-edge clock
//     rst_n  in   asynchronous active-low reset
//     bus    slave modport of innerproduct_stream_if (THETA write,
//            feature stream, result stream, sticky errors)
module innerproduct_stream
   import innerproduct_pkg::*;
#(
   parameter int unsigned N_FEAT = 41,
   parameter int unsigned DW     = 32,
   parameter int unsigned LANES  = 1,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned AW     = $clog2(N_FEAT)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   innerproduct_stream_if.slave bus
);

   localparam int unsigned NBEATS = nbeats(N_FEAT, LANES);
   localparam int unsigned CW     = $clog2(NBEATS + 1);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic [ACC_W-1:0]     acc;
   logic                 h_valid;
   logic [ACC_W-1:0]     h_data;
   logic [1:0]           err;
   logic [DW-1:0]        theta [N_FEAT];

   logic                 accept;
   logic                 last_beat;
   logic                 theta_write;
   logic [1:0]           err_set;
   logic [LANES*DW-1:0]  theta_slice;
   logic [ACC_W-1:0]     beat_sum;
   logic [ACC_W-1:0]     next_acc;

   // Held low during reset so the source cannot push into a block that is
   // being cleared; the state register alone would already read IDLE.
   assign bus.x_ready = rst_n && (state != OUTPUT);
   assign bus.h_valid = h_valid;
   assign bus.h_data  = h_data;
   assign bus.err     = err;

   // Select the THETA words for the current beat's lanes.
   always_comb begin
      theta_slice = '0;
      for (int unsigned k = 0; k < LANES; k++) begin
         int unsigned idx;
         idx = 32'(cnt) * LANES + k;
         for (int unsigned j = 0; j < N_FEAT; j++) begin
            if (j == idx) begin
               theta_slice[k*DW +: DW] = theta[j];
            end
         end
      end
   end

   innerproduct_lane_sum #(
      .N_FEAT (N_FEAT),
      .DW     (DW),
      .LANES  (LANES),
      .ACC_W  (ACC_W),
      .CW     (CW)
   ) u_lane_sum (
      .x_data      (bus.x_data),
      .theta_slice (theta_slice),
      .beat        (cnt),
      .beat_sum    (beat_sum)
   );

   always_comb begin
      accept      = bus.x_valid && (state != OUTPUT);
      last_beat   = (cnt == CW'(NBEATS - 1));
      // The first beat of a vector seeds the accumulator with the bias.
      next_acc    = ((state == IDLE) ? ACC_W'(theta[0]) : acc) + beat_sum;
      theta_write = bus.theta_we && (state == IDLE) && !accept;
      err_set     = '0;
      if (accept && (bus.x_last != last_beat)) begin
         err_set[ERR_LAST] = 1'b1;
      end
      if (bus.theta_we && !theta_write) begin
         err_set[ERR_THETA] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         acc     <= '0;
         h_valid <= 1'b0;
         h_data  <= '0;
         err     <= '0;
         for (int unsigned j = 0; j < N_FEAT; j++) begin
            theta[j] <= '0;
         end
      end else begin
         // A new error in the same cycle as err_clr survives the clear.
         err <= (bus.err_clr ? 2'b00 : err) | err_set;

         if (theta_write) begin
            for (int unsigned j = 0; j < N_FEAT; j++) begin
               if (bus.theta_addr == AW'(j)) begin
                  theta[j] <= bus.theta_wdata;
               end
            end
         end

         case (state)
            IDLE, ACCUM: begin
               if (accept) begin
                  acc <= next_acc;
                  cnt <= cnt + CW'(1);
                  if (last_beat) begin
                     h_data  <= next_acc;
                     h_valid <= 1'b1;
                     state   <= OUTPUT;
                  end else begin
                     state   <= ACCUM;
                  end
               end
            end
            OUTPUT: begin
               if (bus.h_ready) begin
                  h_valid <= 1'b0;
                  cnt     <= '0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_innerproduct_stream.sv
// tb_innerproduct_stream
//   Directed self-checking bench for innerproduct_stream with
//   N_FEAT=5, LANES=2 (three beats per vector, one padding lane).
module tb_innerproduct_stream;

   localparam int unsigned N_FEAT = 5;
   localparam int unsigned DW     = 32;
   localparam int unsigned LANES  = 2;
   localparam int unsigned ACC_W  = 32;
   localparam int unsigned AW     = 3;
   localparam logic [31:0] PAD    = 32'hDEAD_BEEF;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   innerproduct_stream_if #(
      .N_FEAT (N_FEAT), .DW (DW), .LANES (LANES), .ACC_W (ACC_W), .AW (AW)
   ) bus ();

   innerproduct_stream #(
      .N_FEAT (N_FEAT), .DW (DW), .LANES (LANES), .ACC_W (ACC_W), .AW (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
      $fatal(1, "watchdog");
   end

   task automatic idle_inputs();
      bus.theta_we    = 1'b0;
      bus.theta_addr  = '0;
      bus.theta_wdata = '0;
      bus.x_valid     = 1'b0;
      bus.x_data      = '0;
      bus.x_last      = 1'b0;
      bus.h_ready     = 1'b0;
      bus.err_clr     = 1'b0;
   endtask

   task automatic load_theta(input logic [31:0] t [5]);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.theta_we    = 1'b1;
         bus.theta_addr  = 3'(i);
         bus.theta_wdata = t[i];
      end
      @(negedge clk);
      bus.theta_we = 1'b0;
   endtask

   // Presents one beat (optionally with a concurrent THETA write) and
   // returns #1 after the edge on which it was accepted.
   task automatic send_beat(input logic [31:0] lo, input logic [31:0] hi,
                            input logic last, input logic we,
                            input logic [2:0] waddr, input logic [31:0] wdata,
                            input string tag);
      int n;
      n = 0;
      @(negedge clk);
      bus.x_valid     = 1'b1;
      bus.x_data      = {hi, lo};
      bus.x_last      = last;
      bus.theta_we    = we;
      bus.theta_addr  = waddr;
      bus.theta_wdata = wdata;
      while (bus.x_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 20) begin
         n_fail++;
         $display("FAIL %s_ready: x_ready got %b want 1 within 20 cycles", tag, bus.x_ready);
      end
      @(posedge clk);
      #1;
      bus.x_valid  = 1'b0;
      bus.x_last   = 1'b0;
      bus.theta_we = 1'b0;
   endtask

   task automatic send_vec(input logic [31:0] x [5], input logic [2:0] lasts,
                           input string tag);
      send_beat(x[0], x[1], lasts[0], 1'b0, 3'd0, 32'd0, tag);
      send_beat(x[2], x[3], lasts[1], 1'b0, 3'd0, 32'd0, tag);
      send_beat(x[4], PAD,  lasts[2], 1'b0, 3'd0, 32'd0, tag);
   endtask

   // Called #1 after the last beat's acceptance edge: checks the result
   // appeared with one-cycle latency, then consumes it.
   task automatic finish_vec(input logic [31:0] exp, input logic [1:0] exp_err,
                             input string tag);
      n_checks++;
      if (bus.h_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s_hvalid: got %b want 1", tag, bus.h_valid);
      end
      n_checks++;
      if (bus.h_data !== exp) begin
         n_fail++;
         $display("FAIL %s_hdata: got %0d want %0d", tag, bus.h_data, exp);
      end
      n_checks++;
      if (bus.err !== exp_err) begin
         n_fail++;
         $display("FAIL %s_err: got %b want %b", tag, bus.err, exp_err);
      end
      @(negedge clk);
      bus.h_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.h_ready = 1'b0;
      n_checks++;
      if (bus.h_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_consumed: h_valid got %b want 0", tag, bus.h_valid);
      end
   endtask

   task automatic clear_err(input string tag);
      @(negedge clk);
      bus.err_clr = 1'b1;
      @(posedge clk);
      #1;
      bus.err_clr = 1'b0;
      n_checks++;
      if (bus.err !== 2'b00) begin
         n_fail++;
         $display("FAIL %s_errclr: got %b want 00", tag, bus.err);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_checks++;
      if (bus.x_ready !== 1'b0) begin
         n_fail++; $display("FAIL rst_xready: got %b want 0", bus.x_ready);
      end
      n_checks++;
      if (bus.h_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_hvalid: got %b want 0", bus.h_valid);
      end
      n_checks++;
      if (bus.h_data !== 32'd0) begin
         n_fail++; $display("FAIL rst_hdata: got %0d want 0", bus.h_data);
      end
      n_checks++;
      if (bus.err !== 2'b00) begin
         n_fail++; $display("FAIL rst_err: got %b want 00", bus.err);
      end
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (bus.x_ready !== 1'b1) begin
         n_fail++; $display("FAIL rst_release_xready: got %b want 1", bus.x_ready);
      end
   endtask

   // 10 + 2*1 + 3*1 + 4*1 + 5*1 = 24; x0=7 and the padding lane are ignored.
   task automatic test_basic();
      load_theta('{32'd10, 32'd2, 32'd3, 32'd4, 32'd5});
      send_beat(32'd7, 32'd1, 1'b0, 1'b0, 3'd0, 32'd0, "basic");
      send_beat(32'd1, 32'd1, 1'b0, 1'b0, 3'd0, 32'd0, "basic");
      n_checks++;
      if (bus.h_valid !== 1'b0) begin
         n_fail++; $display("FAIL basic_early_hvalid: got %b want 0", bus.h_valid);
      end
      send_beat(32'd1, PAD, 1'b1, 1'b0, 3'd0, 32'd0, "basic");
      finish_vec(32'd24, 2'b00, "basic");
   endtask

   // 10 + 2*0xFFFFFFFF = 10 + 0xFFFFFFFE mod 2^32 = 8
   task automatic test_wrap();
      load_theta('{32'd10, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0});
      send_vec('{32'd0, 32'd2, 32'd0, 32'd0, 32'd0}, 3'b100, "wrap");
      finish_vec(32'd8, 2'b00, "wrap");
   endtask

   task automatic test_backpressure();
      load_theta('{32'd10, 32'd2, 32'd3, 32'd4, 32'd5});
      send_vec('{32'd7, 32'd1, 32'd1, 32'd1, 32'd1}, 3'b100, "bp");
      // Next vector's first beat waits while the result is stalled.
      bus.x_valid = 1'b1;
      bus.x_data  = {32'd2, 32'd7};
      bus.x_last  = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if (bus.h_valid !== 1'b1 || bus.h_data !== 32'd24) begin
            n_fail++;
            $display("FAIL bp_hold%0d: h_valid/h_data got %b/%0d want 1/24", c, bus.h_valid, bus.h_data);
         end
         n_checks++;
         if (bus.x_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_xready%0d: got %b want 0", c, bus.x_ready);
         end
      end
      @(negedge clk);
      bus.h_ready = 1'b1;
      n_checks++;
      if (bus.x_ready !== 1'b0) begin
         n_fail++; $display("FAIL bp_bubble: x_ready got %b want 0", bus.x_ready);
      end
      @(posedge clk);
      #1;
      bus.h_ready = 1'b0;
      n_checks++;
      if (bus.h_valid !== 1'b0) begin
         n_fail++; $display("FAIL bp_consumed: h_valid got %b want 0", bus.h_valid);
      end
      @(negedge clk);
      n_checks++;
      if (bus.x_ready !== 1'b1) begin
         n_fail++; $display("FAIL bp_next_ready: x_ready got %b want 1", bus.x_ready);
      end
      @(posedge clk);
      #1;
      bus.x_valid = 1'b0;
      // 10 + 2*2 + 3*2 + 4*2 + 5*2 = 38
      send_beat(32'd2, 32'd2, 1'b0, 1'b0, 3'd0, 32'd0, "bp2");
      send_beat(32'd2, PAD,   1'b1, 1'b0, 3'd0, 32'd0, "bp2");
      finish_vec(32'd38, 2'b00, "bp2");
   endtask

   task automatic test_dropped_write();
      // Beat 1 write collides with an accepted beat in IDLE, beat 2 write
      // arrives in ACCUM: both are dropped.
      send_beat(32'd7, 32'd1, 1'b0, 1'b1, 3'd1, 32'd9, "drop");
      send_beat(32'd1, 32'd1, 1'b0, 1'b1, 3'd2, 32'd9, "drop");
      send_beat(32'd1, PAD,   1'b1, 1'b0, 3'd0, 32'd0, "drop");
      finish_vec(32'd24, 2'b10, "drop");
      clear_err("drop");
      // THETA must still be the original values for the following vector.
      send_vec('{32'd7, 32'd1, 32'd1, 32'd1, 32'd1}, 3'b100, "drop2");
      // err_clr together with a new dropped write (OUTPUT state): error wins.
      @(negedge clk);
      bus.err_clr  = 1'b1;
      bus.theta_we = 1'b1;
      bus.theta_addr  = 3'd1;
      bus.theta_wdata = 32'd9;
      @(posedge clk);
      #1;
      bus.err_clr  = 1'b0;
      bus.theta_we = 1'b0;
      finish_vec(32'd24, 2'b10, "drop2");
      clear_err("drop2");
   endtask

   task automatic test_last_err();
      send_vec('{32'd7, 32'd1, 32'd1, 32'd1, 32'd1}, 3'b101, "last");
      finish_vec(32'd24, 2'b01, "last");
      clear_err("last");
   endtask

   task automatic test_reset_mid();
      send_beat(32'd7, 32'd1, 1'b0, 1'b0, 3'd0, 32'd0, "rmid");
      send_beat(32'd1, 32'd1, 1'b0, 1'b0, 3'd0, 32'd0, "rmid");
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (bus.h_valid !== 1'b0 || bus.x_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rmid_inreset: h_valid/x_ready got %b/%b want 0/0", bus.h_valid, bus.x_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      // THETA was cleared, so a full vector yields 0.
      send_vec('{32'd7, 32'd1, 32'd1, 32'd1, 32'd1}, 3'b100, "rmid_zero");
      finish_vec(32'd0, 2'b00, "rmid_zero");
      load_theta('{32'd10, 32'd2, 32'd3, 32'd4, 32'd5});
      send_vec('{32'd7, 32'd1, 32'd1, 32'd1, 32'd1}, 3'b100, "rmid_reload");
      finish_vec(32'd24, 2'b00, "rmid_reload");
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_dropped_write();
      test_last_err();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
